// File: rtl/sasa_ctrl_pkg.sv
// Shared types and default sizing for the SASA attention control blocks.
package sasa_ctrl_pkg;

  localparam int SEG_NUM_D = 16;
  localparam int SEQ_LEN_D = 16;
  localparam int TIMEOUT_D = 64;
  localparam int TOTAL     = SEG_NUM_D * SEQ_LEN_D;

  typedef enum logic [2:0] {
    IDLE,
    MAX_RUN,
    MAX_WAIT,
    GAP,
    SUB_RUN,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/mvu_seq_ctrl_if.sv
// Host/MVU handshake bundle between the sequencer and its surroundings.
interface mvu_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int HEAD_W = 3
);
  logic              start;
  logic              abort;
  logic [HEAD_W-1:0] num_heads;
  logic              find_max;
  logic              find_sub;
  logic              max_done_i;
  logic              sub_done_i;
  logic              cam_rd_en;
  logic [ADDR_W-1:0] cam_rd_addr;
  logic [HEAD_W-1:0] head_idx;
  logic              sub_valid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, num_heads, max_done_i, sub_done_i,
    output find_max, find_sub, cam_rd_en, cam_rd_addr, head_idx,
           sub_valid, busy, done, err
  );

  modport slave (
    output start, abort, num_heads, max_done_i, sub_done_i,
    input  find_max, find_sub, cam_rd_en, cam_rd_addr, head_idx,
           sub_valid, busy, done, err
  );
endinterface

// File: rtl/mvu_watchdog.sv
// Wait-state watchdog: cleared on state entry, counts while enabled.
module mvu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_exp
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CW'(1);
  end

  // Fires on the TIMEOUT-th enabled cycle since entry.
  assign o_exp = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mvu_seq_ctrl.sv
// CAM1 match-vector sequencer: per head a FindMax scan, one gap, a FindSub readout.
module mvu_seq_ctrl
  import sasa_ctrl_pkg::*;
#(
  parameter int SEG_NUM = SEG_NUM_D,
  parameter int SEQ_LEN = SEQ_LEN_D,
  parameter int ADDR_W  = 8,
  parameter int HEAD_W  = 3,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic           clk,
  input logic           reset,
  mvu_seq_ctrl_if.master bus
);
  localparam int N_TOT = SEG_NUM * SEQ_LEN;

  state_e            r_state, w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [HEAD_W-1:0] r_head, r_nh;
  logic              r_find_max, r_find_sub, r_cam_en, r_sub_valid;
  logic              r_busy, r_done, r_err;
  logic              w_acc, w_exp, w_wd_clr, w_wd_en;

  assign w_acc    = (r_state == IDLE) && bus.start && !bus.abort;
  assign w_wd_clr = (w_nxt != r_state);
  assign w_wd_en  = (r_state == MAX_WAIT) || (r_state == SUB_RUN);

  mvu_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_wd_clr),
    .i_en  (w_wd_en),
    .o_exp (w_exp)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     if (w_acc) w_nxt = MAX_RUN;
      // An early FindMax done means the MVU and sequencer disagree on scan length.
      MAX_RUN:  if (bus.max_done_i)                    w_nxt = ERR;
                else if (r_addr == ADDR_W'(N_TOT - 1)) w_nxt = MAX_WAIT;
      MAX_WAIT: if (bus.max_done_i) w_nxt = GAP;
                else if (w_exp)     w_nxt = ERR;
      GAP:      w_nxt = SUB_RUN;
      SUB_RUN:  if (bus.sub_done_i)
                  w_nxt = (r_head == r_nh - HEAD_W'(1)) ? DONE : MAX_RUN;
                else if (w_exp) w_nxt = ERR;
      DONE:     w_nxt = IDLE;
      ERR:      w_nxt = ERR;
      default:  w_nxt = IDLE;
    endcase
    if (bus.abort && (r_state != IDLE)) w_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_head      <= '0;
      r_nh        <= '0;
      r_find_max  <= 1'b0;
      r_find_sub  <= 1'b0;
      r_cam_en    <= 1'b0;
      r_sub_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      // FindMax stays up through MAX_WAIT: dropping it clears the MVU counters.
      r_find_max  <= (w_nxt == MAX_RUN) || (w_nxt == MAX_WAIT);
      r_cam_en    <= (w_nxt == MAX_RUN);
      r_find_sub  <= (w_nxt == SUB_RUN);
      r_sub_valid <= r_find_sub;
      r_busy      <= (w_nxt != IDLE);
      r_done      <= (w_nxt == DONE);
      r_err       <= (w_nxt == ERR) || (r_err && !w_acc && !bus.abort);
      if (w_acc) begin
        r_nh   <= (bus.num_heads == '0) ? HEAD_W'(1) : bus.num_heads;
        r_head <= '0;
        r_addr <= '0;
      end else begin
        if ((r_state == MAX_RUN) && (w_nxt == MAX_RUN)) r_addr <= r_addr + ADDR_W'(1);
        else if (w_nxt == GAP)                          r_addr <= '0;
        if ((r_state == SUB_RUN) && (w_nxt == MAX_RUN)) r_head <= r_head + HEAD_W'(1);
      end
    end
  end

  assign bus.find_max    = r_find_max;
  assign bus.find_sub    = r_find_sub;
  assign bus.cam_rd_en   = r_cam_en;
  assign bus.cam_rd_addr = r_addr;
  assign bus.head_idx    = r_head;
  assign bus.sub_valid   = r_sub_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule
